segasys1_sndcmd_tx: RTL

SEGASYS1_SNDCMD_TX -- requirements
Module: segasys1_sndcmd_tx

---
 rtl/segasys1_sndcmd_tx_pkg.sv | 18 +
 rtl/segasys1_sndcmd_fifo.sv | 78 +++++++
 rtl/segasys1_sndcmd_tx.sv | 102 ++++++++++
 3 files changed

// File: rtl/segasys1_sndcmd_tx_pkg.sv
// Shared types and constants for the System 1 sound-command transmitter.
package segasys1_sndcmd_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ASSERT = 2'd1,
        ST_GAP    = 2'd2
    } tx_state_e;

    localparam int unsigned HOLD_CYC_DEF = 12;
    localparam int unsigned GAP_CYC_DEF  = 12;
    localparam int unsigned CMD_W        = 8;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/segasys1_sndcmd_fifo.sv
// Command queue: DEPTH-entry FIFO with SNDCMD_FIFO_EN, otherwise a single
// overwrite-on-write pending register.
module sndcmd_fifo
    import segasys1_sndcmd_tx_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [CMD_W-1:0] din,
    output logic [CMD_W-1:0] dout,
    output logic             empty,
    output logic             full
);

    if ((DEPTH < 2) || (DEPTH > 16) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("sndcmd_fifo: DEPTH must be a power of two in 2..16");
    end

`ifdef SNDCMD_FIFO_EN
    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [PTR_W:0]     wr_ptr;
    logic [PTR_W:0]     rd_ptr;
    logic [CMD_W-1:0]   mem [DEPTH];
    logic               wr_en;

    // Extra MSB on each pointer separates full from empty when the indices match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                   (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign wr_en = push && (!full || pop);
    assign dout  = mem[rd_ptr[PTR_W-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + (PTR_W + 1)'(1);
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + (PTR_W + 1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr[PTR_W-1:0]] <= din;
        end
    end
`else
    logic             valid;
    logic [CMD_W-1:0] data;

    assign empty = !valid;
    assign full  = valid;
    assign dout  = data;

    // A push always lands; with a simultaneous pop the slot stays occupied.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (push) begin
            valid <= 1'b1;
            data  <= din;
        end else if (pop) begin
            valid <= 1'b0;
        end
    end
`endif

endmodule

// File: rtl/segasys1_sndcmd_tx.sv
// Main-CPU to sound-board command transmitter: queues command bytes and
// strobes each one out as a timed sndstart pulse. Macro: SNDCMD_FIFO_EN.
module segasys1_sndcmd_tx
    import segasys1_sndcmd_tx_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned HOLD_CYC   = HOLD_CYC_DEF,
    parameter int unsigned GAP_CYC    = GAP_CYC_DEF
) (
    input  logic             clk48M,
    input  logic             reset_n,
    input  logic             cmd_wr,
    input  logic [CMD_W-1:0] cmd_di,
    input  logic             ovf_clr,
    output logic [CMD_W-1:0] sndno,
    output logic             sndstart,
    output logic             busy,
    output logic             full,
    output logic             overflow
);

    localparam int unsigned CNT_W = $clog2(max_u(HOLD_CYC, GAP_CYC));

    tx_state_e          state;
    logic [CNT_W-1:0]   cnt;
    logic               q_empty;
    logic               q_full;
    logic [CMD_W-1:0]   q_dout;
    logic               pop;

    assign pop  = (state == ST_IDLE) && !q_empty;
    assign full = q_full;
    assign busy = !q_empty || (state != ST_IDLE);

    sndcmd_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk48M),
        .rst_n (reset_n),
        .push  (cmd_wr),
        .pop   (pop),
        .din   (cmd_di),
        .dout  (q_dout),
        .empty (q_empty),
        .full  (q_full)
    );

    // Pulse sequencer: pop into sndno, hold high HOLD_CYC, low GAP_CYC, back to idle.
    always_ff @(posedge clk48M or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            sndno    <= '0;
            sndstart <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!q_empty) begin
                        sndno    <= q_dout;
                        sndstart <= 1'b1;
                        cnt      <= '0;
                        state    <= ST_ASSERT;
                    end
                end
                ST_ASSERT: begin
                    if (cnt == CNT_W'(HOLD_CYC - 1)) begin
                        sndstart <= 1'b0;
                        cnt      <= '0;
                        state    <= ST_GAP;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_GAP: begin
                    if (cnt == CNT_W'(GAP_CYC - 1)) begin
                        cnt   <= '0;
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    sndstart <= 1'b0;
                    cnt      <= '0;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

    // A dropped or overwriting write sets the flag and wins over a same-cycle clear.
    always_ff @(posedge clk48M or negedge reset_n) begin
        if (!reset_n) begin
            overflow <= 1'b0;
        end else if (cmd_wr && q_full && !pop) begin
            overflow <= 1'b1;
        end else if (ovf_clr) begin
            overflow <= 1'b0;
        end
    end

endmodule
